// File: rtl/bram_bank_burst.sv
// -----------------------------------------------------------------------------
// bram_bank_burst
//   Wide multi-lane on-chip buffer: DP lanes of DATA_WIDTH bits, DEPTH words,
//   one shared address per word. A burst command (start address + length) is
//   sequenced internally. Write bursts consume streamed beats with a per-lane
//   mask. Read bursts issue one address per cycle and return data RD_LAT cycles
//   after issue.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   cmd_valid  burst command offered
//   cmd_ready  command accepted (high only while idle)
//   cmd_rw     1 = write burst, 0 = read burst
//   cmd_addr   start word address
//   cmd_len    word count, 0..DEPTH
//   wr_valid   write beat offered
//   wr_ready   write beat accepted
//   wr_mask    per-lane write enable
//   wr_data    write word, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid   read word valid (no backpressure)
//   rd_data    read word, same packing; holds its value when rd_valid is low
//   busy       burst in progress
//   done       one-cycle burst-complete pulse
//   err        one-cycle command-reject pulse
//
// Build option
//   BRAM_BANK_BURST_RANGE_CHK_EN: when defined, commands running past the end
//   of the buffer are consumed without executing and err pulses. When not
//   defined, addresses wrap modulo DEPTH and err is constant 0.
// -----------------------------------------------------------------------------
module bram_bank_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int DP         = 512,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [$clog2(DEPTH)-1:0]      cmd_addr,
    input  logic [$clog2(DEPTH):0]        cmd_len,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DP-1:0]                 wr_mask,
    input  logic [DP*DATA_WIDTH-1:0]      wr_data,
    output logic                          rd_valid,
    output logic [DP*DATA_WIDTH-1:0]      rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int W          = DP * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    // Read pipeline holds only the final word at its output stage.
    localparam logic [RD_LAT-1:0]     VLD_TOP   = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    done_q, done_d;
    logic [RD_LAT-1:0]       vld_q;
    logic [W-1:0]            hold_q;

    logic                    wr_en;
    logic                    rd_issue;
    logic                    cmd_bad;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [W-1:0]            rd_mem;
    logic [W-1:0]            stage_out;

    // Explicit compare so a non-power-of-two DEPTH wraps correctly.
    assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        cmd_ready = (state_q == S_IDLE);
        wr_ready  = 1'b0;
        wr_en     = 1'b0;
        rd_issue  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && !cmd_bad) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        count_d = cmd_len;
                        state_d = cmd_rw ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wr_en   = 1'b1;
                    addr_d  = addr_inc;
                    count_d = count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                rd_issue = 1'b1;
                addr_d   = addr_inc;
                count_d  = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave once the last word is on the output this cycle.
                if (vld_q == VLD_TOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            done_q  <= done_d;
            vld_q   <= (vld_q << 1) | RD_LAT'(rd_issue);
            if (vld_q[RD_LAT-1]) begin
                hold_q <= stage_out;
            end
        end
    end

    // One block RAM per lane; the lane mask gates only that lane's write.
    for (genvar gi = 0; gi < DP; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] lane_rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && wr_mask[gi]) begin
                lane_mem_q[addr_q] <= wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_issue) begin
                lane_rd_q <= lane_mem_q[addr_q];
            end
        end

        assign rd_mem[gi*DATA_WIDTH +: DATA_WIDTH] = lane_rd_q;
    end

    // The RAM output register is the first latency stage; extra stages follow.
    if (RD_LAT == 1) begin : g_lat1
        assign stage_out = rd_mem;
    end else begin : g_latn
        logic [W-1:0] pipe_q [RD_LAT-1];

        always_ff @(posedge clk) begin
            if (vld_q[0]) begin
                pipe_q[0] <= rd_mem;
            end
            for (int k = 1; k < RD_LAT - 1; k++) begin
                if (vld_q[k]) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign stage_out = pipe_q[RD_LAT-2];
    end

    // Output shows the live word when valid, otherwise the last one delivered.
    assign rd_valid = vld_q[RD_LAT-1];
    assign rd_data  = rd_valid ? stage_out : hold_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

`ifdef BRAM_BANK_BURST_RANGE_CHK_EN
    logic [ADDR_WIDTH+1:0] cmd_end;
    logic                  err_q;

    assign cmd_end = (ADDR_WIDTH + 2)'(cmd_addr) + (ADDR_WIDTH + 2)'(cmd_len);
    assign cmd_bad = (cmd_end > (ADDR_WIDTH + 2)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_valid && cmd_ready && cmd_bad;
        end
    end

    assign err = err_q;
`else
    assign cmd_bad = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
